regfile_mp: RTL and testbench

- Parametrised successor to the 8x8 CPU register file. Width and depth are configurable, with an optional hardwired zero register.
- Two combinational read ports with same-cycle write bypass, and two write ports with fixed priority.
- Per-register pending scoreboard for pipeline hazard detection.
- Multi-cycle clear sequencer that zeroes the file on request without a global reset.
- Sits between the decode stage (reads, issue) and the writeback stage (writes) of the five-stage pipeline.

---
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_mp.sv | 153 +++++++++++++++
 tb/tb_regfile_mp.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Register-file bus: decode-side reads/issue and writeback-side writes, plus clear control.
// The pipeline (master) drives addresses/data/enables; the register file (slave) returns data and hazards.
`timescale 1ns/1ps
interface regfile_mp_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] readREG1, readREG2;
  logic [DATA_W-1:0] readDATA1, readDATA2;
  logic              pend1, pend2;
  logic [ADDR_W-1:0] writeREG, writeREG2;
  logic [DATA_W-1:0] writeDATA, writeDATA2;
  logic              writeCTRL, writeCTRL2;
  logic [ADDR_W-1:0] issueREG;
  logic              issueCTRL;
  logic              clrREQ;
  logic              clrBUSY;

  modport master (
    output readREG1, readREG2, writeREG, writeDATA, writeCTRL,
           writeREG2, writeDATA2, writeCTRL2, issueREG, issueCTRL, clrREQ,
    input  readDATA1, readDATA2, pend1, pend2, clrBUSY
  );

  modport slave (
    input  readREG1, readREG2, writeREG, writeDATA, writeCTRL,
           writeREG2, writeDATA2, writeCTRL2, issueREG, issueCTRL, clrREQ,
    output readDATA1, readDATA2, pend1, pend2, clrBUSY
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised 2R/2W register file with same-cycle write bypass, per-register
// pending scoreboard and a one-entry-per-cycle clear sweep.
`timescale 1ns/1ps
module regfile_mp_entry #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              set_pend,
  output logic [DATA_W-1:0] data,
  output logic              pend
);
  logic [DATA_W-1:0] data_q, data_d;
  logic              pend_q, pend_d;

  // An issue landing together with a writeback keeps the entry pending.
  always_comb begin
    data_d = data_q;
    pend_d = pend_q;
    if (clr) begin
      data_d = '0;
      pend_d = 1'b0;
    end else begin
      if (wr_en) begin
        data_d = wr_data;
        pend_d = 1'b0;
      end
      if (set_pend) pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      pend_q <= 1'b0;
    end else begin
      data_q <= data_d;
      pend_q <= pend_d;
    end
  end

  assign data = data_q;
  assign pend = pend_q;
endmodule

module regfile_mp #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic clk,
  input  logic rst,
  regfile_mp_if.slave rf
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              busy_q;

  logic                         idle, wa, wb, iss;
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0]             pend_v;
  logic [1:0][ADDR_W-1:0]       ra;
  logic [1:0][DATA_W-1:0]       rd;
  logic [1:0]                   pd;

  assign idle = (state_q == IDLE);
  // Accesses to the hardwired zero register are dropped at the source.
  assign wa  = idle && rf.writeCTRL  && !(ZERO_REG != 0 && rf.writeREG  == '0);
  assign wb  = idle && rf.writeCTRL2 && !(ZERO_REG != 0 && rf.writeREG2 == '0);
  assign iss = idle && rf.issueCTRL  && !(ZERO_REG != 0 && rf.issueREG  == '0);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign mem[i]    = '0;
      assign pend_v[i] = 1'b0;
    end else begin : g_reg
      logic hit_a, hit_b;
      assign hit_a = wa && (rf.writeREG  == ADDR_W'(i));
      assign hit_b = wb && (rf.writeREG2 == ADDR_W'(i));
      regfile_mp_entry #(.DATA_W(DATA_W)) u_ent (
        .clk      (clk),
        .rst      (rst),
        .clr      (!idle && (ptr_q == ADDR_W'(i))),
        .wr_en    (hit_a || hit_b),
        .wr_data  (hit_a ? rf.writeDATA : rf.writeDATA2),
        .set_pend (iss && (rf.issueREG == ADDR_W'(i))),
        .data     (mem[i]),
        .pend     (pend_v[i])
      );
    end
  end

  assign ra = {rf.readREG2, rf.readREG1};

  // wa/wb are already gated by IDLE, so the sweep sees raw array contents.
  always_comb begin
    rd = '0;
    pd = '0;
    for (int p = 0; p < 2; p++) begin
      if (wa && rf.writeREG == ra[p])       rd[p] = rf.writeDATA;
      else if (wb && rf.writeREG2 == ra[p]) rd[p] = rf.writeDATA2;
      else                                  rd[p] = mem[ra[p]];
      pd[p] = pend_v[ra[p]] &&
              !((wa && rf.writeREG == ra[p]) || (wb && rf.writeREG2 == ra[p]));
    end
  end

  assign rf.readDATA1 = rd[0];
  assign rf.readDATA2 = rd[1];
  assign rf.pend1     = pd[0];
  assign rf.pend2     = pd[1];
  assign rf.clrBUSY   = busy_q;

  // Terminal compare precedes the increment, so the sweep never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rf.clrREQ) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          if (ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ptr_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed hazard/bypass/sweep cases on a plain
// and a zero-register instance, then a randomized phase against a reference model.
`timescale 1ns/1ps
module tb_regfile_mp;
  localparam int DW = 8, AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW)) zbus ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) u_dut  (.clk(clk), .rst(rst), .rf(bus.slave));
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) u_dutz (.clk(clk), .rst(rst), .rf(zbus.slave));

  localparam int S_RD1 = 0, S_RD2 = 1, S_P1 = 2, S_P2 = 3, S_BUSY = 4, S_ZRD1 = 5, S_ZP1 = 6;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk = 0, n_err = 0;

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      S_RD1:   return bus.readDATA1;
      S_RD2:   return bus.readDATA2;
      S_P1:    return {7'd0, bus.pend1};
      S_P2:    return {7'd0, bus.pend2};
      S_BUSY:  return {7'd0, bus.clrBUSY};
      S_ZRD1:  return zbus.readDATA1;
      default: return {7'd0, zbus.pend1};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input string tag, input int sel, input logic [7:0] v);
    sb_t e;
    e.tag = tag; e.sel = sel; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    bus.writeCTRL = 0; bus.writeCTRL2 = 0; bus.issueCTRL = 0; bus.clrREQ = 0;
    bus.writeREG = 0; bus.writeREG2 = 0; bus.writeDATA = 0; bus.writeDATA2 = 0; bus.issueREG = 0;
    zbus.writeCTRL = 0; zbus.writeCTRL2 = 0; zbus.issueCTRL = 0; zbus.clrREQ = 0;
    zbus.writeREG = 0; zbus.writeREG2 = 0; zbus.writeDATA = 0; zbus.writeDATA2 = 0; zbus.issueREG = 0;
    zbus.readREG1 = 0; zbus.readREG2 = 0;
  endtask

  task automatic wr_a(input logic [2:0] a, input logic [7:0] d);
    bus.writeCTRL = 1; bus.writeREG = a; bus.writeDATA = d;
  endtask

  task automatic wr_b(input logic [2:0] a, input logic [7:0] d);
    bus.writeCTRL2 = 1; bus.writeREG2 = a; bus.writeDATA2 = d;
  endtask

  int          cnt;
  logic [7:0]  m [8];
  logic        pm [8];
  logic        rwa, rwb, ris;
  logic [2:0]  raa, rab, rai, ra;
  logic [7:0]  rda, rdb, e_rd;
  logic        e_pd;

  initial begin
    quiet();
    bus.readREG1 = 3; bus.readREG2 = 5;
    rst = 1;
    step(); step();
    rst = 0;
    exp_push("rst_rd1", S_RD1, 8'h00); exp_push("rst_rd2", S_RD2, 8'h00);
    exp_push("rst_p1", S_P1, 0); exp_push("rst_p2", S_P2, 0); exp_push("rst_busy", S_BUSY, 0);
    drain();

    // write with same-cycle bypass on port 2
    wr_a(3, 8'h5A); bus.readREG2 = 3;
    exp_push("byp_rd2", S_RD2, 8'h5A); drain();
    step(); quiet();
    bus.readREG1 = 3; exp_push("wr_rd1", S_RD1, 8'h5A); drain();

    // port priority and dual commit
    wr_a(5, 8'h11); wr_b(5, 8'h22); bus.readREG1 = 5;
    exp_push("pri_byp", S_RD1, 8'h11); drain();
    step();
    wr_a(1, 8'h33); wr_b(2, 8'h44); bus.readREG2 = 2;
    exp_push("bypB_rd2", S_RD2, 8'h44); drain();
    step(); quiet();
    bus.readREG1 = 5; exp_push("pri_r5", S_RD1, 8'h11); drain();
    bus.readREG1 = 1; bus.readREG2 = 2;
    exp_push("dual_r1", S_RD1, 8'h33); exp_push("dual_r2", S_RD2, 8'h44); drain();

    // scoreboard
    bus.issueCTRL = 1; bus.issueREG = 4; bus.readREG1 = 4; bus.readREG2 = 4;
    exp_push("iss_same", S_P1, 0); drain();
    step(); quiet();
    exp_push("iss_p1", S_P1, 1); exp_push("iss_p2", S_P2, 1); drain();
    step();
    wr_b(4, 8'h99);
    exp_push("wb_mask", S_P1, 0); exp_push("wb_byp", S_RD1, 8'h99); drain();
    step(); quiet();
    exp_push("wb_clr", S_P1, 0); drain();
    bus.issueCTRL = 1; bus.issueREG = 4; wr_a(4, 8'h55);
    step(); quiet();
    exp_push("iss_win", S_P1, 1); exp_push("iss_win_d", S_RD1, 8'h55); drain();

    // hardwired zero register
    zbus.writeCTRL = 1; zbus.writeREG = 0; zbus.writeDATA = 8'hFF; zbus.readREG1 = 0;
    exp_push("z_nobyp", S_ZRD1, 8'h00); drain();
    step();
    zbus.writeCTRL = 0; zbus.issueCTRL = 1; zbus.issueREG = 0;
    exp_push("z_rd", S_ZRD1, 8'h00); drain();
    step(); zbus.issueCTRL = 0;
    exp_push("z_pend", S_ZP1, 0); drain();
    zbus.writeCTRL = 1; zbus.writeREG = 1; zbus.writeDATA = 8'hC3; zbus.readREG1 = 1;
    exp_push("z_r1_byp", S_ZRD1, 8'hC3); drain();
    step(); zbus.writeCTRL = 0;

    // fill, then sweep; r7 written in the same cycle as clrREQ
    for (int k = 0; k < 4; k++) begin
      wr_a(3'(2*k), 8'(2*k*17 + 1)); wr_b(3'(2*k+1), 8'((2*k+1)*17 + 1));
      step();
    end
    quiet();
    bus.issueCTRL = 1; bus.issueREG = 6;
    step(); quiet();
    bus.readREG2 = 6; exp_push("pre_p6", S_P2, 1); drain();
    bus.clrREQ = 1; wr_a(7, 8'h78);
    step(); bus.clrREQ = 0; bus.writeCTRL = 0;
    bus.readREG1 = 6; bus.readREG2 = 7;
    wr_a(7, 8'hEE); bus.issueCTRL = 1; bus.issueREG = 7;
    exp_push("sw_nobyp", S_RD2, 8'h78); exp_push("sw_p6", S_P1, 1); exp_push("sw_p7m", S_P2, 0); drain();
    cnt = 0;
    while (bus.clrBUSY && cnt < 20) begin
      cnt++;
      step();
    end
    quiet();
    chk("sweep_len", 8'(cnt), 8'd8);
    for (int i = 0; i < 8; i++) begin
      bus.readREG1 = 3'(i); bus.readREG2 = 3'(i);
      exp_push("post_rd", S_RD1, 8'h00); exp_push("post_p", S_P2, 0); drain();
    end

    // reset in cycle 3 of a sweep, then restart
    wr_a(3, 8'h77); step(); quiet();
    bus.clrREQ = 1; step(); bus.clrREQ = 0;
    step(); step();
    exp_push("sw3_busy", S_BUSY, 1); drain();
    rst = 1; step(); rst = 0;
    bus.readREG1 = 3; bus.readREG2 = 1;
    exp_push("rs_busy", S_BUSY, 0); exp_push("rs_r3", S_RD1, 8'h00); exp_push("rs_r1", S_RD2, 8'h00); drain();
    bus.clrREQ = 1; step(); bus.clrREQ = 0;
    cnt = 0;
    while (bus.clrBUSY && cnt < 20) begin
      cnt++;
      step();
    end
    chk("resweep_len", 8'(cnt), 8'd8);

    // randomized traffic against a reference model
    for (int i = 0; i < 8; i++) begin m[i] = 0; pm[i] = 0; end
    for (int c = 0; c < 150; c++) begin
      rwa = 1'($urandom_range(0, 1)); rwb = 1'($urandom_range(0, 1)); ris = 1'($urandom_range(0, 1));
      raa = 3'($urandom_range(0, 7)); rab = 3'($urandom_range(0, 7)); rai = 3'($urandom_range(0, 7));
      rda = 8'($urandom_range(0, 255)); rdb = 8'($urandom_range(0, 255));
      bus.writeCTRL = rwa; bus.writeREG = raa; bus.writeDATA = rda;
      bus.writeCTRL2 = rwb; bus.writeREG2 = rab; bus.writeDATA2 = rdb;
      bus.issueCTRL = ris; bus.issueREG = rai;
      bus.readREG1 = 3'($urandom_range(0, 7)); bus.readREG2 = 3'($urandom_range(0, 7));
      for (int p = 0; p < 2; p++) begin
        ra = (p == 0) ? bus.readREG1 : bus.readREG2;
        if (rwa && raa == ra)      e_rd = rda;
        else if (rwb && rab == ra) e_rd = rdb;
        else                       e_rd = m[ra];
        e_pd = pm[ra] && !((rwa && raa == ra) || (rwb && rab == ra));
        exp_push(p == 0 ? "rnd_rd1" : "rnd_rd2", p == 0 ? S_RD1 : S_RD2, e_rd);
        exp_push(p == 0 ? "rnd_p1" : "rnd_p2", p == 0 ? S_P1 : S_P2, {7'd0, e_pd});
      end
      drain();
      if (rwb) begin m[rab] = rdb; pm[rab] = 0; end
      if (rwa) begin m[raa] = rda; pm[raa] = 0; end
      if (ris) pm[rai] = 1;
      step();
    end
    quiet();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
